// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal UART family: FSM state encoding, parity
// modes and helpers that the transmitter and the future receiver both use.
package cereal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } cereal_state_t;

    localparam int PARITY_NONE   = 32'sd0;
    localparam int PARITY_ODD    = 32'sd1;
    localparam int PARITY_EVEN   = 32'sd2;
    localparam int MAX_DATA_BITS = 32'sd9;

    // True when the frame format is one the cereal blocks can build.
    function automatic logic cereal_params_ok(
        input int div,
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        logic ok_s;
        ok_s = (div >= 32'sd2)
            && (data_bits >= 32'sd5) && (data_bits <= 32'sd9)
            && (parity >= 32'sd0) && (parity <= 32'sd2)
            && ((stop_bits == 32'sd1) || (stop_bits == 32'sd2));
        return ok_s;
    endfunction

    // Parity over a zero-extended word; the padding zeros leave the XOR unchanged.
    function automatic logic cereal_parity(
        input logic [MAX_DATA_BITS-1:0] data,
        input int                       parity
    );
        logic p_s;
        case (parity)
            PARITY_EVEN: p_s = ^data;
            PARITY_ODD:  p_s = ~^data;
            default:     p_s = 1'b0;
        endcase
        return p_s;
    endfunction

endpackage

// File: rtl/cereal_tx_baud_tick.sv
// Bit-period divider: emits a one-cycle tick every DIV clocks, restarted by
// clear so the first bit after an accepted word is never short.
module baud_tick #(
    parameter int DIV = 5208
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Bit-period counter, wraps after LAST or restarts on clear.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/cereal_tx.sv
// Parametrised UART transmitter: one word per valid/ready handshake, sent as
// start, data LSB first, optional parity and 1-2 stop bits on a flopped tx pin.
module cereal_tx
    import cereal_pkg::*;
#(
    parameter int DIV       = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    if (!cereal_params_ok(DIV, DATA_BITS, PARITY, STOP_BITS)) begin : g_param_err
        $error("cereal_tx: illegal parameter set");
    end

    localparam int             MAX_BITS  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int             BCW       = $clog2(MAX_BITS + 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
    localparam logic           HAS_PAR   = (PARITY != PARITY_NONE);

    cereal_state_t        state_r,    state_nxt_s;
    logic [DATA_BITS-1:0] shreg_r,    shreg_nxt_s;
    logic [BCW-1:0]       bit_cnt_r,  bit_cnt_nxt_s;
    logic                 parity_r,   parity_nxt_s;
    logic                 tx_r,       tx_nxt_s;
    logic                 busy_r;
    logic                 in_ready_r;
    logic                 accept_s;
    logic                 tick_s;

    assign accept_s = in_valid && (state_r == ST_IDLE);

    baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .clear  (accept_s),
        .tick   (tick_s)
    );

    // Frame sequencing: next state, shift register, bit counter and parity latch.
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        parity_nxt_s  = parity_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = ST_START;
                    shreg_nxt_s   = in_data;
                    parity_nxt_s  = cereal_parity(MAX_DATA_BITS'(in_data), PARITY);
                    bit_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shreg_nxt_s = {1'b0, shreg_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == DATA_LAST) begin
                        state_nxt_s   = HAS_PAR ? ST_PARITY : ST_STOP;
                        bit_cnt_nxt_s = '0;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_nxt_s   = ST_STOP;
                    bit_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (bit_cnt_r == STOP_LAST) begin
                        state_nxt_s   = ST_IDLE;
                        bit_cnt_nxt_s = '0;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                bit_cnt_nxt_s = '0;
            end
        endcase
    end

    // Line level for the state being entered, so tx changes on the same edge as the state.
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shreg_nxt_s[0];
            ST_PARITY: tx_nxt_s = parity_nxt_s;
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase
    end

    // State and output flops; reset drives the line idle immediately.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            bit_cnt_r  <= '0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            shreg_r    <= shreg_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            parity_r   <= parity_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            in_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign in_ready = in_ready_r;

endmodule

// File: tb/tb_cereal_tx.sv
// Directed bench for cereal_tx: several parameterisations side by side,
// each frame compared cycle by cycle against hand-built bit patterns.
module tb_cereal_tx;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] data_8;
    logic [4:0] data_5;
    logic       v_a, v_e, v_o, v_5, v_s;
    logic       tx_a, busy_a, rdy_a;
    logic       tx_e, busy_e, rdy_e;
    logic       tx_o, busy_o, rdy_o;
    logic       tx_5, busy_5, rdy_5;
    logic       tx_s, busy_s, rdy_s;

    int errors = 0;
    int checks = 0;

    cereal_tx #(.DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sysclk(sysclk), .rst_n(rst_n), .in_data(data_8), .in_valid(v_a),
        .in_ready(rdy_a), .tx(tx_a), .busy(busy_a));

    cereal_tx #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .sysclk(sysclk), .rst_n(rst_n), .in_data(data_8), .in_valid(v_e),
        .in_ready(rdy_e), .tx(tx_e), .busy(busy_e));

    cereal_tx #(.DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .sysclk(sysclk), .rst_n(rst_n), .in_data(data_8), .in_valid(v_o),
        .in_ready(rdy_o), .tx(tx_o), .busy(busy_o));

    cereal_tx #(.DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .sysclk(sysclk), .rst_n(rst_n), .in_data(data_5), .in_valid(v_5),
        .in_ready(rdy_5), .tx(tx_5), .busy(busy_5));

    cereal_tx #(.DIV(5208), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
        .sysclk(sysclk), .rst_n(rst_n), .in_data(data_8), .in_valid(v_s),
        .in_ready(rdy_s), .tx(tx_s), .busy(busy_s));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // {tx, busy, in_ready} of the selected instance
    function automatic logic [2:0] obs(input int which);
        case (which)
            0:       return {tx_a, busy_a, rdy_a};
            1:       return {tx_e, busy_e, rdy_e};
            2:       return {tx_o, busy_o, rdy_o};
            3:       return {tx_5, busy_5, rdy_5};
            default: return {tx_s, busy_s, rdy_s};
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Call one sample after the accept edge; bits[b] is the line level of bit b (4 clocks each).
    task automatic check_frame(input string tag, input int which, input int nbits, input logic [11:0] bits);
        logic [2:0] o;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                o = obs(which);
                chk($sformatf("%s_b%0d_c%0d_tx", tag, b, c), 32'(o[2]), 32'(bits[b]));
                chk($sformatf("%s_b%0d_c%0d_busy", tag, b, c), 32'(o[1]), 32'd1);
                chk($sformatf("%s_b%0d_c%0d_rdy", tag, b, c), 32'(o[0]), 32'd0);
                step(1);
            end
        end
        o = obs(which);
        chk($sformatf("%s_end_tx", tag), 32'(o[2]), 32'd1);
        chk($sformatf("%s_end_busy", tag), 32'(o[1]), 32'd0);
        chk($sformatf("%s_end_rdy", tag), 32'(o[0]), 32'd1);
    endtask

    initial begin
        int k;
        int low_w;
        logic seen_high;
        logic [9:0] slow_bits;

        rst_n  = 1'b0;
        data_8 = 8'h00;
        data_5 = 5'h00;
        v_a = 1'b0; v_e = 1'b0; v_o = 1'b0; v_5 = 1'b0; v_s = 1'b0;

        // 1: reset state, then reset during a frame
        #23;
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rdy", 32'(rdy_a), 32'd1);
        chk("rst_slow_tx", 32'(tx_s), 32'd1);
        rst_n = 1'b1;
        step(2);
        chk("post_rst_tx", 32'(tx_a), 32'd1);
        chk("post_rst_rdy", 32'(rdy_a), 32'd1);

        data_8 = 8'h00;
        v_a    = 1'b1;
        step(1);
        v_a = 1'b0;
        step(5);
        chk("midframe_tx_low", 32'(tx_a), 32'd0);
        chk("midframe_busy", 32'(busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx_a), 32'd1);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_rdy", 32'(rdy_a), 32'd1);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("rel_tx", 32'(tx_a), 32'd1);
        chk("rel_busy", 32'(busy_a), 32'd0);
        chk("rel_rdy", 32'(rdy_a), 32'd1);

        // 2: 8N1 0xA5, input data changed right after accept
        data_8 = 8'hA5;
        v_a    = 1'b1;
        step(1);
        v_a    = 1'b0;
        data_8 = 8'h00;
        check_frame("a5_8n1", 0, 10, {2'b00, 1'b1, 8'hA5, 1'b0});

        // 3: 0x07 with even parity (p=1) then odd parity (p=0)
        step(2);
        data_8 = 8'h07;
        v_e    = 1'b1;
        step(1);
        v_e = 1'b0;
        check_frame("07_8e1", 1, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0});
        step(2);
        v_o = 1'b1;
        step(1);
        v_o = 1'b0;
        check_frame("07_8o1", 2, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0});

        // 4: 5 data bits, 2 stop bits
        step(2);
        data_5 = 5'h1F;
        v_5    = 1'b1;
        step(1);
        v_5 = 1'b0;
        check_frame("1f_5n2", 3, 8, {4'b0000, 2'b11, 5'h1F, 1'b0});

        // 5: valid held high back-to-back; next word presented mid-frame
        step(2);
        data_8 = 8'h55;
        v_a    = 1'b1;
        step(1);
        data_8 = 8'hAA;
        check_frame("b2b_55", 0, 10, {2'b00, 1'b1, 8'h55, 1'b0});
        step(1);
        v_a = 1'b0;
        check_frame("b2b_aa", 0, 10, {2'b00, 1'b1, 8'hAA, 1'b0});

        // 6: real baud divider, start width and whole-frame length
        step(2);
        data_8 = 8'h41;
        v_s    = 1'b1;
        step(1);
        v_s       = 1'b0;
        slow_bits = {1'b1, 8'h41, 1'b0};
        k         = 0;
        low_w     = 0;
        seen_high = 1'b0;
        while (busy_s && (k < 60000)) begin
            if (!seen_high) begin
                if (tx_s == 1'b0) low_w++;
                else seen_high = 1'b1;
            end
            if ((k % 5208) == 2604) begin
                chk($sformatf("slow_bit%0d_tx", k / 5208), 32'(tx_s), 32'(slow_bits[k / 5208]));
            end
            step(1);
            k++;
        end
        chk("slow_start_width", 32'(low_w), 32'd5208);
        chk("slow_frame_len", 32'(k), 32'd52080);
        chk("slow_end_tx", 32'(tx_s), 32'd1);
        chk("slow_end_rdy", 32'(rdy_s), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
